// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcode map, ALU operation codes and
// the control-sequencer state encoding.
package cpu_pkg;

    localparam int OPCODE_W = 4;
    localparam int ALU_OP_W = 4;

    localparam logic [OPCODE_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADD   = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_SUB   = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_AND   = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_OR    = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_XOR   = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_STORE = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_JMP   = 4'h9;
    localparam logic [OPCODE_W-1:0] OP_HALT  = 4'hF;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // True for the states in which the decoded ALU controls are presented.
    function automatic logic alu_active(input state_t s);
        return (s == ST_DECODE) || (s == ST_EXEC) || (s == ST_MEM) || (s == ST_WB);
    endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decoder: maps an opcode to ALU controls and the
// instruction-class flags used by the control sequencer.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src,
    output logic                is_load,
    output logic                is_store,
    output logic                is_jump,
    output logic                writes_reg,
    output logic                illegal
);

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        alu_op     = ALU_ADD;
        alu_src    = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_jump    = 1'b0;
        writes_reg = 1'b0;
        illegal    = 1'b0;

        case (opcode)
            OP_NOP: ;
            OP_ADD: begin
                alu_op     = ALU_ADD;
                writes_reg = 1'b1;
            end
            OP_SUB: begin
                alu_op     = ALU_SUB;
                writes_reg = 1'b1;
            end
            OP_AND: begin
                alu_op     = ALU_AND;
                writes_reg = 1'b1;
            end
            OP_OR: begin
                alu_op     = ALU_OR;
                writes_reg = 1'b1;
            end
            OP_XOR: begin
                alu_op     = ALU_XOR;
                writes_reg = 1'b1;
            end
            OP_ADDI: begin
                alu_op     = ALU_ADD;
                alu_src    = 1'b1;
                writes_reg = 1'b1;
            end
            // Memory address comes straight from the source register.
            OP_LOAD: begin
                alu_op     = ALU_PASSB;
                is_load    = 1'b1;
                writes_reg = 1'b1;
            end
            OP_STORE: begin
                alu_op   = ALU_PASSB;
                is_store = 1'b1;
            end
            OP_JMP:  is_jump = 1'b1;
            OP_HALT: ;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/[MEM]/WB, drives datapath strobes and counts retirements.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int                  RETIRE_W    = 16,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = 4'hF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                run,
    input  logic                step,
    output logic                reg_write,
    output logic                mem_write,
    output logic                alu_src,
    output logic                mem_to_reg,
    output logic                jump,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                pc_en,
    output logic                instr_done,
    output logic                illegal,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired_cnt
);

    state_t              state;
    state_t              state_nxt;
    logic [OPCODE_W-1:0] op_q;
    logic [OPCODE_W-1:0] dec_opcode;

    logic [ALU_OP_W-1:0] dec_alu_op;
    logic                dec_alu_src;
    logic                dec_is_load;
    logic                dec_is_store;
    logic                dec_is_jump;
    logic                dec_writes_reg;
    logic                dec_illegal;

    // DECODE sees the live opcode; from EXEC on, only the captured copy counts.
    assign dec_opcode = (state == ST_DECODE) ? opcode : op_q;

    cpu_decode u_decode (
        .opcode     (dec_opcode),
        .alu_op     (dec_alu_op),
        .alu_src    (dec_alu_src),
        .is_load    (dec_is_load),
        .is_store   (dec_is_store),
        .is_jump    (dec_is_jump),
        .writes_reg (dec_writes_reg),
        .illegal    (dec_illegal)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            op_q  <= OP_NOP;
        end else begin
            state <= state_nxt;
            if (state == ST_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (run || step) state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC:   state_nxt = (dec_is_load || dec_is_store) ? ST_MEM : ST_WB;
            ST_MEM:    state_nxt = ST_WB;
            ST_WB: begin
                if (op_q == HALT_OPCODE) begin
                    state_nxt = ST_HALT;
                end else if (run) begin
                    state_nxt = ST_FETCH;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        alu_op     = '0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        jump       = 1'b0;
        pc_en      = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        halted     = (state == ST_HALT);

        if (alu_active(state)) begin
            alu_op  = dec_alu_op;
            alu_src = dec_alu_src;
        end

        if (state == ST_MEM) begin
            mem_write  = dec_is_store;
            mem_to_reg = dec_is_load;
        end

        // Every instruction, HALT included, retires in WB.
        if (state == ST_WB) begin
            mem_to_reg = dec_is_load;
            reg_write  = dec_writes_reg;
            jump       = dec_is_jump;
            illegal    = dec_illegal;
            pc_en      = 1'b1;
            instr_done = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_cnt <= '0;
        end else if (instr_done) begin
            retired_cnt <= retired_cnt + RETIRE_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: directed scenarios plus random
// instruction streams compared against a per-cycle strobe model.
module tb_cpu_control_fsm;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  opcode;
    logic        run;
    logic        step;
    logic        reg_write, mem_write, alu_src, mem_to_reg, jump;
    logic [3:0]  alu_op;
    logic        pc_en, instr_done, illegal, halted;
    logic [15:0] retired_cnt;

    // Narrow-counter instance so the wrap from all-ones to zero is reachable quickly.
    logic        run_w;
    logic        reg_write_w, mem_write_w, alu_src_w, mem_to_reg_w, jump_w;
    logic [3:0]  alu_op_w;
    logic        pc_en_w, instr_done_w, illegal_w, halted_w;
    logic [1:0]  retired_cnt_w;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] cnt_model = '0;

    cpu_control_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .run         (run),
        .step        (step),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .alu_src     (alu_src),
        .mem_to_reg  (mem_to_reg),
        .jump        (jump),
        .alu_op      (alu_op),
        .pc_en       (pc_en),
        .instr_done  (instr_done),
        .illegal     (illegal),
        .halted      (halted),
        .retired_cnt (retired_cnt)
    );

    cpu_control_fsm #(.RETIRE_W(2)) dut_w (
        .clk         (clk),
        .reset       (reset),
        .opcode      (4'h0),
        .run         (run_w),
        .step        (1'b0),
        .reg_write   (reg_write_w),
        .mem_write   (mem_write_w),
        .alu_src     (alu_src_w),
        .mem_to_reg  (mem_to_reg_w),
        .jump        (jump_w),
        .alu_op      (alu_op_w),
        .pc_en       (pc_en_w),
        .instr_done  (instr_done_w),
        .illegal     (illegal_w),
        .halted      (halted_w),
        .retired_cnt (retired_cnt_w)
    );

    always #5 clk = ~clk;

    logic [12:0] obs;
    assign obs = {reg_write, mem_write, alu_src, mem_to_reg, jump, alu_op,
                  pc_en, instr_done, illegal, halted};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] exp_alu(input logic [3:0] op);
        case (op)
            4'h2:       return 4'd1;
            4'h3:       return 4'd2;
            4'h4:       return 4'd3;
            4'h5:       return 4'd4;
            4'h7, 4'h8: return 4'd5;
            default:    return 4'd0;
        endcase
    endfunction

    // Expected strobes for cycle k (1 = FETCH) of an instruction with opcode op.
    function automatic logic [12:0] exp_vec(input logic [3:0] op, input int k);
        bit ld  = (op == 4'h7);
        bit st  = (op == 4'h8);
        int len = (ld || st) ? 5 : 4;
        bit ret = (k == len);
        logic [3:0] a  = (k >= 2) ? exp_alu(op) : 4'd0;
        bit         as = (k >= 2) && (op == 4'h6);
        bit         rw = ret && (op >= 4'h1) && (op <= 4'h7);
        bit         mw = st && (k == 4);
        bit         mr = ld && (k >= 4);
        bit         jp = ret && (op == 4'h9);
        bit         il = ret && (op >= 4'hA) && (op <= 4'hE);
        return {rw, mw, as, mr, jp, a, ret, ret, il, 1'b0};
    endfunction

    // Called at a negedge just before the edge that enters FETCH.
    task automatic run_instr(input logic [3:0] op, input bit use_step, input bit keep_run,
                             input bit extra_step, input string tag);
        int len = (op == 4'h7 || op == 4'h8) ? 5 : 4;
        opcode = op;
        if (use_step) step = 1'b1;
        for (int k = 1; k <= len; k++) begin
            @(posedge clk);
            @(negedge clk);
            step = 1'b0;
            check($sformatf("%s op%0h c%0d strobes", tag, op, k), 32'(obs), 32'(exp_vec(op, k)));
            check($sformatf("%s op%0h c%0d cnt", tag, op, k), 32'(retired_cnt), 32'(cnt_model));
            if (k == 2) begin
                run = keep_run;
                if (extra_step) step = 1'b1;
            end
            if (k == 3) opcode = 4'($urandom_range(0, 15));
        end
        cnt_model++;
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s idle%0d strobes", tag, i), 32'(obs), 32'h0);
            check($sformatf("%s idle%0d cnt", tag, i), 32'(retired_cnt), 32'(cnt_model));
        end
    endtask

    initial begin
        logic [3:0] rop;
        bit         idle;
        bit         us;
        bit         keep;
        int         seen;

        reset  = 1'b1;
        run    = 1'b0;
        step   = 1'b0;
        opcode = 4'h0;
        run_w  = 1'b0;

        // Reset held, then released with run=0.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset strobes", 32'(obs), 32'h0);
        check("reset cnt", 32'(retired_cnt), 32'h0);
        idle_check("post_reset", 2);

        // Free-run ADD with run and step arriving together as one start.
        run = 1'b1;
        run_instr(4'h1, 1'b1, 1'b1, 1'b0, "add");
        run_instr(4'h8, 1'b0, 1'b1, 1'b0, "store");
        run_instr(4'h7, 1'b0, 1'b0, 1'b0, "load");
        idle_check("post_load", 1);

        // Single-step JMP; a second step mid-instruction is dropped.
        run_instr(4'h9, 1'b1, 1'b0, 1'b1, "jmp");
        idle_check("post_jmp", 2);

        run_instr(4'hC, 1'b1, 1'b0, 1'b0, "illegal");
        idle_check("post_illegal", 1);

        // Random instruction mix, switching between free-run and single-step.
        idle = 1'b1;
        for (int n = 0; n < 40; n++) begin
            rop  = 4'($urandom_range(0, 14));
            us   = idle && ($urandom_range(0, 1) == 1);
            keep = ($urandom_range(0, 3) != 0);
            if (!us) run = 1'b1;
            run_instr(rop, us, keep, 1'b0, "rand");
            idle = !keep;
            if (idle) idle_check("rand", 1);
        end

        // HALT retires like any instruction, then only reset leaves it.
        if (idle) run = 1'b0;
        run_instr(4'hF, idle, 1'b1, 1'b0, "halt");
        @(posedge clk);
        @(negedge clk);
        check("halted level", 32'(obs), 32'h1);
        step = 1'b1;
        run  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            step = 1'b0;
            check($sformatf("halt ignore%0d strobes", i), 32'(obs), 32'h1);
            check($sformatf("halt ignore%0d cnt", i), 32'(retired_cnt), 32'(cnt_model));
        end

        // Reset landing in the MEM state of a STORE aborts it without mem_write.
        run   = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        cnt_model = '0;
        check("rereset strobes", 32'(obs), 32'h0);
        check("rereset cnt", 32'(retired_cnt), 32'h0);
        run    = 1'b1;
        opcode = 4'h8;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("abort c%0d strobes", k), 32'(obs), 32'(exp_vec(4'h8, k)));
        end
        run = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort mem_write", 32'(mem_write), 32'h0);
        check("abort strobes", 32'(obs), 32'h0);
        reset = 1'b0;
        idle_check("post_abort", 2);

        // Retired counter wraps from all-ones to zero.
        run_w = 1'b1;
        seen  = 0;
        for (int c = 0; c < 40 && seen < 3; c++) begin
            @(negedge clk);
            if (instr_done_w) seen++;
        end
        check("wrap reached three retires", 32'(seen), 32'd3);
        @(negedge clk);
        check("wrap cnt all-ones", 32'(retired_cnt_w), 32'd3);
        seen = 0;
        for (int c = 0; c < 20 && seen < 1; c++) begin
            @(negedge clk);
            if (instr_done_w) seen++;
        end
        check("wrap fourth retire", 32'(seen), 32'd1);
        @(negedge clk);
        check("wrap cnt zero", 32'(retired_cnt_w), 32'd0);
        run_w = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
